// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: tracks in-flight destinations over DEPTH stages
// and picks forward sources or stalls for each source operand of the issuing instruction.
module hazard_scoreboard #(
  parameter int unsigned NREG       = 32,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned ALU_AVAIL  = 0,
  parameter int unsigned LOAD_AVAIL = 2,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned RW        = $clog2(NREG),
  localparam int unsigned SW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [RW-1:0]    issue_rd,
  input  logic             issue_wen,
  input  logic             issue_is_load,
  input  logic [RW-1:0]    issue_rs1,
  input  logic [RW-1:0]    issue_rs2,
  input  logic             issue_use1,
  input  logic             issue_use2,
  input  logic             flush,
  output logic             stall,
  output logic [SW-1:0]    fwd_sel1,
  output logic [SW-1:0]    fwd_sel2,
  output logic [CNT_W-1:0] stall_count
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] ld_q, ld_d;
  logic [RW-1:0]    rd_q [DEPTH];
  logic [RW-1:0]    rd_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [RW-1:0]    src [2];
  logic [1:0]       use_v;
  logic [1:0]       found;
  logic [1:0]       nready;
  logic [SW-1:0]    sel [2];
  logic             accept;

  // Ascending scan with a found flag so the youngest (lowest stage) match wins.
  always_comb begin
    src[0] = issue_rs1;
    src[1] = issue_rs2;
    use_v  = {issue_use2, issue_use1};
    found  = '0;
    nready = '0;
    sel[0] = '0;
    sel[1] = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      if (use_v[s] && (src[s] != '0)) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (!found[s] && vld_q[k] && (rd_q[k] == src[s])) begin
            found[s] = 1'b1;
            if (k >= (ld_q[k] ? LOAD_AVAIL : ALU_AVAIL)) sel[s] = SW'(k + 1);
            else                                          nready[s] = 1'b1;
          end
        end
      end
    end
  end

  assign stall       = issue_valid & ~flush & (|nready);
  assign accept      = issue_valid & issue_wen & ~stall & ~flush & (issue_rd != '0);
  assign fwd_sel1    = sel[0];
  assign fwd_sel2    = sel[1];
  assign stall_count = cnt_q;

  always_comb begin
    vld_d[0] = accept;
    rd_d[0]  = issue_rd;
    ld_d[0]  = issue_is_load;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      rd_d[k]  = rd_q[k-1];
      ld_d[k]  = ld_q[k-1];
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) rd_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the core's 2-bit mini scoreboard. Tracks in-flight destination registers across a configurable number of post-issue pipeline stages.
- For each instruction being issued, it decides per source operand whether to read the register bank or forward from a given stage, or to stall.
- Sits between fetch/decode (issue side) and execute (forward mux select). Supports a configurable load-use latency, a flush, and a stall performance counter.

Parameters:
- NREG, 32: number of architectural registers; register index width RW = clog2(NREG); register 0 is hardwired zero.
- DEPTH, 3: in-flight stages tracked after issue (stage 0 = execute, DEPTH-1 = writeback).
- ALU_AVAIL, 0: first stage index at which a non-load result is forwardable.
- LOAD_AVAIL, 2: first stage index at which load data is forwardable. Legal range is ALU_AVAIL <= LOAD_AVAIL < DEPTH.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_rd  in  RW  destination register of the issuing instruction.
- issue_wen  in  1  issuing instruction writes issue_rd.
- issue_is_load  in  1  issuing instruction is a load.
- issue_rs1  in  RW  source register 1 index.
- issue_rs2  in  RW  source register 2 index.
- issue_use1  in  1  rs1 is actually read.
- issue_use2  in  1  rs2 is actually read.
- flush  in  1  squash the issuing instruction (taken branch).
- stall  out  1  hold fetch/decode; the issuing instruction is not accepted.
- fwd_sel1  out  clog2(DEPTH+1)  0 = register bank, k+1 = forward from stage k.
- fwd_sel2  out  clog2(DEPTH+1)  same encoding for rs2.
- stall_count  out  CNT_W  number of cycles in which stall was asserted.

Behaviour:
- State: DEPTH entries {valid, rd, is_load}. Entry k holds the instruction currently in stage k.
- Reset: all entries invalid; stall_count=0. With an empty table, stall=0 and fwd_sel1=fwd_sel2=0. Reset mid-operation discards every in-flight entry in the same edge.
- Every cycle, entries shift: entry[k] <= entry[k-1] for k=1..DEPTH-1. Entry DEPTH-1 retires, because the bank write happens at that edge.
- Entry[0] is loaded from the issue port:
  - valid = issue_valid & issue_wen & ~stall & ~flush & (issue_rd != 0).
  - Otherwise entry[0] receives a bubble (valid=0).
- Hazard lookup is combinational from current state, done per source s with use flag set and index != 0:
  - Find the lowest k with entry[k].valid and entry[k].rd == s. The youngest match wins.
  - No match: fwd_sel = 0.
  - Match with avail = (is_load ? LOAD_AVAIL : ALU_AVAIL) and k >= avail: fwd_sel = k+1.
  - Match with k < avail: source is not ready and contributes a stall.
- Source index 0 or use flag low: never a hazard, fwd_sel = 0.
- stall = OR of the per-source not-ready conditions, gated by issue_valid & ~flush. fwd_sel values are don't-care while stall=1.
- During a stall, decode holds the same instruction. Older entries keep advancing and a bubble enters stage 0, so a stall always resolves within LOAD_AVAIL cycles.
- flush and stall in the same cycle: flush wins. stall=0 and a bubble is inserted.
- Fetch is not the block's concern.
- stall_count increments by 1 on every cycle with stall=1. It saturates at all-ones, with no wrap.
- Latency: zero-cycle combinational decision. The table updates on the next rising edge.

Test Plan:
- Defaults; issue x5=ADD at t, then at t+1 issue use1 rs1=x5 -> stall=0, fwd_sel1=1. At t+2 the same query gives fwd_sel1=2. At t+3 it gives fwd_sel1=3. At t+4 it gives 0.
- Load x7 at t; dependent rs2=x7 at t+1 -> stall=1 at t+1 and t+2. At t+3 stall=0, fwd_sel2=3. stall_count=2.
- issue_rd=x0 load followed by a reader of x0 -> never stalls, fwd_sel=0. Likewise use1=0 with a matching rs1 -> no stall.
- ADD x3 at t, ADD x3 at t+1, reader of x3 at t+2 -> fwd_sel1=1 (youngest match), not 2.
- Load x4 then dependent instruction with flush=1 during the first stall cycle -> stall=0 that cycle, no entry inserted, stall_count unchanged.
- Fill the table with three valid writes, assert reset for one cycle -> next cycle every query gives fwd_sel=0, stall=0, stall_count=0. Separately, force 2^CNT_W+3 stall cycles -> stall_count stays all-ones.
